// File: rtl/frame_line_fetch_arbiter.sv
// frame_line_fetch_arbiter
//   Shares the single-port thermal frame RAM between the sensor writer and
//   the VGA line prefetch. A rising edge on LINE_REQ_i copies one source line
//   (LINE_LEN pixels) from the frame RAM into the display line buffer. Sensor
//   writes are slotted into the idle gaps between fetches. Each source row is
//   shown 2^SCALE_SHIFT times, so a request for the row already in the line
//   buffer completes immediately without touching the RAM.
// Ports
//   CLK, RESET                 clock, async active-high reset
//   ENABLE_i                   accept new requests / writes
//   LINE_REQ_i, COUNTER_ROW_i  row read enable (edge = request), VGA row index
//   SENS_WR_*                  sensor write valid/ready handshake, addr, data
//   RAM_*                      frame RAM port (read data one cycle after EN&!WE)
//   LB_*                       line buffer write port
//   LINE_BUSY_o, LINE_DONE_o   fetch in progress, line buffer ready pulse
//   OVERRUN_o                  sticky: request arrived while busy
module frame_line_fetch_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int LINE_LEN    = 80,
  parameter int LB_ADDR_W   = 7,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE_i,
  input  logic                 LINE_REQ_i,
  input  logic [9:0]           COUNTER_ROW_i,
  input  logic                 SENS_WR_VALID_i,
  input  logic [ADDR_W-1:0]    SENS_WR_ADDR_i,
  input  logic [DATA_W-1:0]    SENS_WR_DATA_i,
  output logic                 SENS_WR_READY_o,
  output logic                 RAM_EN_o,
  output logic                 RAM_WE_o,
  output logic [ADDR_W-1:0]    RAM_ADDR_o,
  output logic [DATA_W-1:0]    RAM_WDATA_o,
  input  logic [DATA_W-1:0]    RAM_RDATA_i,
  output logic                 LB_WE_o,
  output logic [LB_ADDR_W-1:0] LB_ADDR_o,
  output logic [DATA_W-1:0]    LB_DATA_o,
  output logic                 LINE_BUSY_o,
  output logic                 LINE_DONE_o,
  output logic                 OVERRUN_o
);

  localparam int SRC_W = 10 - SCALE_SHIFT;
  localparam logic [LB_ADDR_W-1:0] LAST_IDX = LB_ADDR_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [LB_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]      base_q;
  logic [SRC_W-1:0]       row_q, cache_row_q;
  logic                   cache_vld_q;
  logic                   req_d_q;
  logic                   done_q;
  logic                   overrun_q;
  logic                   lb_we_q;
  logic [LB_ADDR_W-1:0]   lb_addr_q;
  logic                   wr_vld_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;

  logic                   req_edge, is_idle, start, hit, wr_accept;
  logic [SRC_W-1:0]       src_row;
  logic [ADDR_W-1:0]      base_d;

  // Edges are tracked regardless of ENABLE so that a level held across an
  // ENABLE toggle does not look like a fresh request later.
  assign req_edge  = LINE_REQ_i & ~req_d_q;
  assign src_row   = SRC_W'(COUNTER_ROW_i >> SCALE_SHIFT);
  assign base_d    = ADDR_W'(ADDR_W'(src_row) * ADDR_W'(LINE_LEN));
  assign is_idle   = (state_q == S_IDLE);
  assign hit       = cache_vld_q & (src_row == cache_row_q);
  assign start     = is_idle & ENABLE_i & req_edge;
  // Line requests win the collision; the writer simply sees READY low.
  // Reset forces every output low, including this combinational one.
  assign SENS_WR_READY_o = ENABLE_i & is_idle & ~req_edge & ~RESET;
  assign wr_accept       = SENS_WR_VALID_i & SENS_WR_READY_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start && !hit) begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      row_q       <= '0;
      cache_row_q <= '0;
      cache_vld_q <= 1'b0;
      req_d_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= '0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_d_q   <= LINE_REQ_i;
      if (start && !hit) begin
        base_q <= base_d;
        row_q  <= src_row;
      end
      // DRAIN carries the last line buffer write; done and cache update
      // become visible together on the following cycle.
      done_q <= (start & hit) | (state_q == S_DRAIN);
      if (state_q == S_DRAIN) begin
        cache_vld_q <= 1'b1;
        cache_row_q <= row_q;
      end
      if (!is_idle && ENABLE_i && req_edge) overrun_q <= 1'b1;
      // RAM read data lands one cycle after the address, so the line buffer
      // write trails the read by one cycle.
      lb_we_q   <= (state_q == S_FETCH);
      lb_addr_q <= cnt_q;
      wr_vld_q  <= wr_accept;
      if (wr_accept) begin
        wr_addr_q <= SENS_WR_ADDR_i;
        wr_data_q <= SENS_WR_DATA_i;
      end
    end
  end

  // An accepted write is only ever pending while IDLE, so it never overlaps
  // a fetch read.
  always_comb begin
    RAM_EN_o    = 1'b0;
    RAM_WE_o    = 1'b0;
    RAM_ADDR_o  = '0;
    RAM_WDATA_o = '0;
    if (state_q == S_FETCH) begin
      RAM_EN_o   = 1'b1;
      RAM_ADDR_o = base_q + ADDR_W'(cnt_q);
    end else if (wr_vld_q) begin
      RAM_EN_o    = 1'b1;
      RAM_WE_o    = 1'b1;
      RAM_ADDR_o  = wr_addr_q;
      RAM_WDATA_o = wr_data_q;
    end
  end

  assign LB_WE_o     = lb_we_q;
  assign LB_ADDR_o   = lb_addr_q;
  assign LB_DATA_o   = lb_we_q ? RAM_RDATA_i : '0;
  assign LINE_BUSY_o = ~is_idle;
  assign LINE_DONE_o = done_q;
  assign OVERRUN_o   = overrun_q;

endmodule
